lsu: RTL and testbench

Load/store unit for the RV32I core, sitting directly downstream of the ALU in the memory stage. It takes the ALU result as the effective address and rs2 data as the store value. It runs one request/ready transaction on the data-memory bus, with byte-lane steering and sign/zero extension. It reports completion, or a fault, to the writeback stage with a one-cycle pulse.

---
 rtl/lsu.sv | 197 +++++++++++++++++++
 tb/tb_lsu.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// RV32I load/store unit: decodes a memory-stage request, runs one req/ready
// bus access with byte-lane steering and load extension, reports done/fault.
//
// state    | meaning
// S_IDLE   | waiting for start; decode and latch request
// S_ACCESS | mem_req high until mem_ready or timeout
// S_DONE   | one-cycle done pulse, fault qualified by cause
module lsu #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        is_load_q, is_load_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    logic        f3_legal, illegal, misaligned;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] rd_shift, ld_ext;

    always_comb begin
        f3_legal = 1'b0;
        if (is_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default: f3_legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                default: f3_legal = 1'b0;
            endcase
        end
        illegal    = (is_load == is_store) || !f3_legal;
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

        st_wstrb = 4'b1111;
        st_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << addr[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_wstrb = 4'b0011 << addr[1:0];
                st_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend by access type.
    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
            3'b101:  ld_ext = {16'h0, rd_shift[15:0]};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        is_load_d   = is_load_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        load_data_d = load_data_q;
        fault_d     = fault_q;
        cause_d     = cause_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (illegal) begin
                        fault_d = 1'b1;
                        cause_d = 2'b10;
                        state_d = S_DONE;
                    end else if (misaligned) begin
                        fault_d = 1'b1;
                        cause_d = 2'b01;
                        state_d = S_DONE;
                    end else begin
                        fault_d     = 1'b0;
                        cause_d     = 2'b00;
                        cnt_d       = 8'd0;
                        funct3_d    = funct3;
                        off_d       = addr[1:0];
                        is_load_d   = is_load;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wstrb_d = is_store ? st_wstrb : 4'b0000;
                        mem_wdata_d = is_store ? st_wdata : mem_wdata_q;
                        state_d     = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    if (is_load_q) begin
                        load_data_d = ld_ext;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(MEM_TIMEOUT)) begin
                        fault_d = 1'b1;
                        cause_d = 2'b11;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            is_load_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            load_data_q <= 32'h0;
            fault_q     <= 1'b0;
            cause_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            is_load_q   <= is_load_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign fault       = done && fault_q;
    assign fault_cause = fault ? cause_q : 2'b00;
    assign mem_req     = (state_q == S_ACCESS);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign load_data   = load_data_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and random requests checked cycle by cycle
// against a byte-level reference model of the load/store rules.
module tb_lsu;
    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_load = 32'h0;

    lsu #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .load_data(load_data), .fault(fault), .fault_cause(fault_cause),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected fault cause for a request: 10 illegal, 01 misaligned, 00 ok.
    function automatic logic [1:0] model_cause(input bit il, input bit is_st,
                                               input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int size;
        int lo;
        if (il == is_st) return 2'b10;
        if (il) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else    legal = (f3 <= 2);
        if (!legal) return 2'b10;
        size = 1 << f3[1:0];
        lo   = int'(a[1:0]);
        if ((lo % size) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic void model_store(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] sd,
                                        output logic [3:0] strb, output logic [31:0] wd);
        int size;
        int off;
        size = 1 << f3[1:0];
        off  = int'(a[1:0]);
        for (int i = 0; i < 4; i++) begin
            strb[i]      = (i >= off) && (i < off + size);
            wd[8*i +: 8] = sd[8*(i % size) +: 8];
        end
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int b[5];
        int off;
        int v;
        for (int i = 0; i < 4; i++) b[i] = int'(rd[8*i +: 8]);
        b[4] = 0;
        off = int'(a[1:0]);
        v = 0;
        case (f3)
            3'b000: begin v = b[off]; if (v >= 128) v = v - 256; end
            3'b001: begin v = b[off] + 256 * b[off+1]; if (v >= 32768) v = v - 65536; end
            3'b100: v = b[off];
            3'b101: v = b[off] + 256 * b[off+1];
            default: return rd;
        endcase
        return 32'(v);
    endfunction

    // Drives one request starting in the current cycle (called #1 after an edge),
    // checks every cycle, and returns in the first idle cycle afterwards so that
    // consecutive calls are back to back. poke holds start high while busy.
    task automatic run_access(input bit il, input bit is_st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rd, input int k, input bit poke,
                              input string tag);
        logic [1:0]  ecause;
        logic [3:0]  estrb;
        logic [31:0] ewd;
        ecause = model_cause(il, is_st, f3, a);
        estrb = 4'b0000;
        ewd   = 32'h0;
        if (is_st && ecause == 2'b00) model_store(f3, a, sd, estrb, ewd);

        start = 1'b1; is_load = il; is_store = is_st; funct3 = f3;
        addr = a; store_data = sd; mem_ready = 1'b0; mem_rdata = $urandom;
        @(posedge clk); #1;

        if (ecause != 2'b00) begin
            n_cmp++;
            if ({busy, done, fault, mem_req} !== 4'b1110) begin
                n_err++;
                $display("FAIL %s fault_ctl: got busy/done/fault/req=%b want 1110", tag,
                         {busy, done, fault, mem_req});
            end
            n_cmp++;
            if (fault_cause !== ecause) begin
                n_err++;
                $display("FAIL %s fault_cause: got %b want %b", tag, fault_cause, ecause);
            end
            start = poke; is_load = 1'($urandom); is_store = 1'($urandom);
            funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
            mem_ready = 1'($urandom);
            @(posedge clk); #1;
        end else begin
            for (int c = 1; c <= k; c++) begin
                n_cmp++;
                if ({busy, mem_req, done} !== 3'b110) begin
                    n_err++;
                    $display("FAIL %s access_ctl c%0d: got busy/req/done=%b want 110", tag, c,
                             {busy, mem_req, done});
                end
                n_cmp++;
                if ({mem_addr, mem_we, mem_wstrb} !== {a[31:2], 2'b00, is_st, estrb}) begin
                    n_err++;
                    $display("FAIL %s bus c%0d: got addr=%h we=%b strb=%b want addr=%h we=%b strb=%b",
                             tag, c, mem_addr, mem_we, mem_wstrb, {a[31:2], 2'b00}, is_st, estrb);
                end
                if (is_st) begin
                    n_cmp++;
                    if (mem_wdata !== ewd) begin
                        n_err++;
                        $display("FAIL %s wdata c%0d: got %h want %h", tag, c, mem_wdata, ewd);
                    end
                end
                start = poke; is_load = 1'($urandom); is_store = 1'($urandom);
                funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
                mem_ready = (c == k);
                mem_rdata = (c == k) ? rd : $urandom;
                @(posedge clk); #1;
            end
            if (il) exp_load = model_load(f3, a, rd);
            n_cmp++;
            if ({busy, done, fault, mem_req, fault_cause} !== 6'b110000) begin
                n_err++;
                $display("FAIL %s done_ctl: got busy/done/fault/req/cause=%b want 110000", tag,
                         {busy, done, fault, mem_req, fault_cause});
            end
            n_cmp++;
            if (load_data !== exp_load) begin
                n_err++;
                $display("FAIL %s load_data: got %h want %h", tag, load_data, exp_load);
            end
            mem_ready = 1'($urandom);
            mem_rdata = $urandom;
            @(posedge clk); #1;
        end

        n_cmp++;
        if ({busy, done, mem_req, fault, fault_cause} !== 5'b00000) begin
            n_err++;
            $display("FAIL %s idle_after: got busy/done/req/fault/cause=%b want 00000", tag,
                     {busy, done, mem_req, fault, fault_cause});
        end
        n_cmp++;
        if (load_data !== exp_load) begin
            n_err++;
            $display("FAIL %s load_hold: got %h want %h", tag, load_data, exp_load);
        end
        start = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, fault, fault_cause, mem_req, mem_we, mem_wstrb} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want all zero",
                     {busy, done, fault, fault_cause, mem_req, mem_we, mem_wstrb});
        end
        n_cmp++;
        if ({load_data, mem_addr, mem_wdata} !== 96'h0) begin
            n_err++;
            $display("FAIL reset_data: got ld=%h addr=%h wd=%h want 0", load_data, mem_addr,
                     mem_wdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, mem_req, done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release: got busy/req/done=%b want 000", {busy, mem_req, done});
        end
        mem_ready = 1'b0;
        exp_load = 32'h0;
    endtask

    task automatic test_store_lanes;
        run_access(0, 1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1, 0, "sw");
        run_access(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 2, 0, "sb3");
        run_access(0, 1, 3'b001, 32'h0000_1002, 32'h0000_1234, 32'h0, 1, 0, "sh2");
        n_cmp++;
        if (mem_wdata !== 32'h1234_1234 || mem_wstrb !== 4'b1100) begin
            n_err++;
            $display("FAIL sh2_latched: got wd=%h strb=%b want 12341234 1100", mem_wdata, mem_wstrb);
        end
    endtask

    task automatic test_load_extract;
        run_access(1, 0, 3'b000, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 1, 0, "lb1");
        n_cmp++;
        if (load_data !== 32'h0000_007F) begin
            n_err++; $display("FAIL lb1_const: got %h want 0000007f", load_data);
        end
        run_access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 2, 0, "lb3");
        n_cmp++;
        if (load_data !== 32'hFFFF_FF80) begin
            n_err++; $display("FAIL lb3_const: got %h want ffffff80", load_data);
        end
        run_access(1, 0, 3'b100, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 1, 0, "lbu2");
        n_cmp++;
        if (load_data !== 32'h0000_00FF) begin
            n_err++; $display("FAIL lbu2_const: got %h want 000000ff", load_data);
        end
        run_access(1, 0, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 3, 0, "lh2");
        n_cmp++;
        if (load_data !== 32'hFFFF_80FF) begin
            n_err++; $display("FAIL lh2_const: got %h want ffff80ff", load_data);
        end
        run_access(1, 0, 3'b101, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 1, 0, "lhu0");
        n_cmp++;
        if (load_data !== 32'h0000_7F01) begin
            n_err++; $display("FAIL lhu0_const: got %h want 00007f01", load_data);
        end
        run_access(1, 0, 3'b010, 32'h0000_1004, 32'h0, 32'hCAFE_F00D, 4, 0, "lw_k4");
    endtask

    task automatic test_faults;
        run_access(1, 0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 1, 0, "lw_misal");
        run_access(1, 1, 3'b010, 32'h0000_1000, 32'h0, 32'h0, 1, 0, "both");
        run_access(0, 0, 3'b000, 32'h0000_1000, 32'h0, 32'h0, 1, 0, "neither");
        run_access(1, 0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 1, 0, "ld_f3_011");
        run_access(0, 1, 3'b100, 32'h0000_1000, 32'h0, 32'h0, 1, 0, "st_f3_100");
        run_access(0, 1, 3'b001, 32'h0000_1001, 32'h0, 32'h0, 1, 1, "sh_misal_poke");
        run_access(1, 1, 3'b001, 32'h0000_1001, 32'h0, 32'h0, 1, 0, "illegal_prio");
    endtask

    task automatic test_timeout;
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        addr = 32'h0000_2000; store_data = 32'h0; mem_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            n_cmp++;
            if ({busy, mem_req, done} !== 3'b110) begin
                n_err++;
                $display("FAIL timeout_req c%0d: got busy/req/done=%b want 110", c,
                         {busy, mem_req, done});
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if ({done, fault, fault_cause, mem_req} !== 5'b11110) begin
            n_err++;
            $display("FAIL timeout_done: got done/fault/cause/req=%b want 11110",
                     {done, fault, fault_cause, mem_req});
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        n_cmp++;
        if ({busy, done, mem_req} !== 3'b000 || load_data !== exp_load) begin
            n_err++;
            $display("FAIL timeout_after: got busy/done/req=%b ld=%h want 000 ld=%h",
                     {busy, done, mem_req}, load_data, exp_load);
        end
    endtask

    task automatic test_drop_start;
        run_access(1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'h0BAD_CAFE, 3, 1, "drop_lw");
        run_access(0, 1, 3'b000, 32'h0000_3001, 32'h0000_0077, 32'h0, 2, 1, "drop_sb");
    endtask

    task automatic test_reset_mid;
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        addr = 32'h0000_4000; store_data = 32'h0; mem_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_err++; $display("FAIL rstmid_req1: got %b want 1", mem_req);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_load = 32'h0;
        n_cmp++;
        if ({mem_req, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_kill: got req/busy/done=%b want 000", {mem_req, busy, done});
        end
        for (int c = 0; c < 4; c++) begin
            mem_ready = 1'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if ({done, busy} !== 2'b00) begin
                n_err++;
                $display("FAIL rstmid_nodone c%0d: got done/busy=%b want 00", c, {done, busy});
            end
        end
        mem_ready = 1'b0;
        run_access(1, 0, 3'b010, 32'h0000_4000, 32'h0, 32'h5555_AAAA, 2, 0, "rstmid_lw");
    endtask

    task automatic test_back_to_back;
        run_access(0, 1, 3'b010, 32'h0000_5000, 32'h0102_0304, 32'h0, 1, 0, "b2b_sw");
        run_access(1, 0, 3'b001, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 1, 0, "b2b_lh");
        run_access(1, 0, 3'b000, 32'h0000_5000, 32'h0, 32'h0000_0080, 1, 0, "b2b_lb");
    endtask

    task automatic test_random;
        bit          il, is_st;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                il = 1'($urandom); is_st = il;
            end else begin
                il = 1'($urandom); is_st = !il;
            end
            f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (il && $urandom_range(0, 2) == 0) f3[2] = 1'b1;
            a = $urandom;
            run_access(il, is_st, f3, a, $urandom, $urandom, $urandom_range(1, TO),
                       1'($urandom), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_store_lanes();
        test_load_extract();
        test_faults();
        test_timeout();
        test_drop_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
